// File: rtl/pwm_multi_if.sv
// Bus bundle for pwm_multi: configuration/strobe inputs and registered PWM outputs.
// dir_state exposes the counter direction (0 = up, 1 = down) for observation.
interface pwm_multi_if #(
    parameter int N  = 8,
    parameter int CH = 4
);
    logic            en;
    logic            mode;
    logic [N-1:0]    period;
    logic [CH*N-1:0] duty;
    logic            load;
    logic [CH-1:0]   pwm_out;
    logic            period_end;
    logic            pending;
    logic            dir_state;

    // load is a plain one-cycle strobe with no back-pressure: a value is taken
    // on every rising edge where load=1, and pending reports an unapplied shadow.
    modport master (
        output en, mode, period, duty, load,
        input  pwm_out, period_end, pending, dir_state
    );

    modport slave (
        input  en, mode, period, duty, load,
        output pwm_out, period_end, pending, dir_state
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with edge/center-aligned counting and
// double-buffered (shadow/active) mode, period and duty registers.
module pwm_multi #(
    parameter int N  = 8,
    parameter int CH = 4
) (
    input  logic      clk,
    input  logic      rst,
    pwm_multi_if.slave bus
);
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    localparam logic [N-1:0] ONE = 1;

    dir_t            dir_q, dir_d;
    logic [N-1:0]    cnt_q, cnt_d;
    logic            boundary;
    logic            apply;

    logic            mode_a, mode_s;
    logic [N-1:0]    p_a, p_s;
    logic [CH*N-1:0] d_a, d_s;
    logic            pending_q;
    logic [CH-1:0]   pwm_q;
    logic            period_end_q;

    // Boundary is the enabled cycle whose next count is 0.
    always_comb begin
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        if (!bus.en) begin
            dir_d = UP;
            cnt_d = '0;
        end else if (p_a == '0) begin
            boundary = 1'b1;
            dir_d    = UP;
            cnt_d    = '0;
        end else if (!mode_a) begin
            if (cnt_q == p_a) begin
                boundary = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            case (dir_q)
                UP: begin
                    if (cnt_q == p_a) begin
                        cnt_d = cnt_q - ONE;
                        dir_d = DOWN;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                DOWN:    cnt_d = cnt_q - ONE;
                default: cnt_d = '0;
            endcase
            if (cnt_d == '0) begin
                boundary = 1'b1;
                dir_d    = UP;
            end
        end
    end

    assign apply = pending_q && (boundary || !bus.en);

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= UP;
            cnt_q <= '0;
        end else begin
            dir_q <= dir_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_a       <= 1'b0;
            p_a          <= '0;
            d_a          <= '0;
            mode_s       <= 1'b0;
            p_s          <= '0;
            d_s          <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            period_end_q <= boundary;
            for (int i = 0; i < CH; i++) begin
                pwm_q[i] <= bus.en && (cnt_q < d_a[i*N +: N]);
            end
            // The old shadow is applied even when a new load lands in the same cycle.
            if (apply) begin
                mode_a <= mode_s;
                p_a    <= p_s;
                d_a    <= d_s;
            end
            if (bus.load) begin
                mode_s <= bus.mode;
                p_s    <= bus.period;
                d_s    <= bus.duty;
            end
            pending_q <= bus.load || (pending_q && !apply);
        end
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.period_end = period_end_q;
    assign bus.pending    = pending_q;
    assign bus.dir_state  = dir_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Randomized and directed bench for pwm_multi, checked by a period-position
// reference model feeding an expected-response queue.
module tb_pwm_multi;
    localparam int N  = 8;
    localparam int CH = 2;
    localparam int W  = CH + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_multi_if #(.N(N), .CH(CH)) bus ();
    pwm_multi #(.N(N), .CH(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position within the current period, active and shadow config.
    bit m_mode_a, m_mode_s, m_pend;
    int m_p_a, m_p_s;
    int m_d_a[CH];
    int m_d_s[CH];
    int pos;

    function automatic int period_len(bit md, int p);
        if (p == 0) return 1;
        return md ? 2 * p : p + 1;
    endfunction

    function automatic int count_at(bit md, int p, int k);
        if (!md || k <= p) return k;
        return 2 * p - k;
    endfunction

    task automatic model_reset();
        m_mode_a = 0; m_mode_s = 0; m_pend = 0;
        m_p_a = 0; m_p_s = 0; pos = 0;
        for (int i = 0; i < CH; i++) begin
            m_d_a[i] = 0;
            m_d_s[i] = 0;
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit ld, input bit md,
                         input logic [N-1:0] p, input logic [CH*N-1:0] dv);
        logic [CH-1:0] pw;
        bit pe, ap;
        int c;
        rst = r; bus.en = e; bus.load = ld; bus.mode = md; bus.period = p; bus.duty = dv;
        pw = '0; pe = 0; ap = 0;
        if (r) begin
            model_reset();
        end else begin
            if (!e) begin
                pos = 0;
                ap  = m_pend;
            end else begin
                c = count_at(m_mode_a, m_p_a, pos);
                for (int i = 0; i < CH; i++) pw[i] = (c < m_d_a[i]);
                pe  = (pos == period_len(m_mode_a, m_p_a) - 1);
                ap  = m_pend && pe;
                pos = pe ? 0 : pos + 1;
            end
            if (ap) begin
                m_mode_a = m_mode_s;
                m_p_a    = m_p_s;
                for (int i = 0; i < CH; i++) m_d_a[i] = m_d_s[i];
            end
            if (ld) begin
                m_mode_s = md;
                m_p_s    = int'(p);
                for (int i = 0; i < CH; i++) m_d_s[i] = int'(dv[i*N +: N]);
            end
            m_pend = ld || (m_pend && !ap);
        end
        exp_q.push_back({pw, pe, m_pend});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit e);
        logic [CH*N-1:0] junk;
        for (int k = 0; k < n; k++) begin
            junk = {$urandom, $urandom};
            drive(0, e, 0, 1'($urandom_range(0, 1)), N'($urandom_range(0, 255)), junk);
        end
    endtask

    task automatic load_cfg(input bit md, input int p, input int d0, input int d1);
        drive(0, 1, 1, md, N'(p), {N'(d1), N'(d0)});
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pwm_out", int'(bus.pwm_out), int'(e[W-1:2]));
                check("period_end", int'(bus.period_end), int'(e[1]));
                check("pending", int'(bus.pending), int'(e[0]));
            end
        end
    end

    initial begin : stimulus
        bit en_r;
        logic [CH*N-1:0] dv;
        model_reset();
        drive(1, 1, 1, 1, 8'd7, '1);
        drive(1, 0, 0, 0, 8'd0, '0);
        drive(1, 0, 0, 0, 8'd0, '0);

        load_cfg(0, 9, 3, 10);
        idle(32, 1);
        load_cfg(0, 9, 0, 10);
        idle(25, 1);
        load_cfg(0, 9, 3, 10);
        idle(12, 1);
        for (int k = 0; k < 64 && pos != 4; k++) idle(1, 1);
        load_cfg(0, 9, 7, 10);
        idle(25, 1);

        load_cfg(1, 4, 2, 5);
        idle(30, 1);
        for (int k = 0; k < 64 && pos != period_len(m_mode_a, m_p_a) - 1; k++) idle(1, 1);
        load_cfg(0, 5, 2, 1);
        idle(20, 1);

        idle(3, 1);
        idle(3, 0);
        idle(15, 1);
        load_cfg(0, 6, 3, 4);
        idle(4, 1);
        drive(1, 1, 0, 0, 8'd0, '0);
        idle(10, 1);

        en_r = 1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 29) == 0) en_r = ~en_r;
            for (int i = 0; i < CH; i++) dv[i*N +: N] = N'($urandom_range(0, 15));
            drive($urandom_range(0, 299) == 0, en_r, $urandom_range(0, 11) == 0,
                  1'($urandom_range(0, 1)), N'($urandom_range(0, 12)), dv);
        end

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
